// File: rtl/sig_cond_pkg.sv
// Shared signal-conditioning definitions: debounce FSM state encodings and
// the helper that maps a state to its debounced output level.
package sig_cond_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b11,
    S_WAIT_LOW  = 2'b10
  } sig_state_e;

  localparam int unsigned SYNC_STAGES_DEF     = 32'd2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd4;

  // The encoding puts the debounced level in bit 1 (HIGH and WAIT_LOW hold 1).
  function automatic logic level_of(input sig_state_e st);
    return st[1];
  endfunction

endpackage

// File: rtl/sig_in_debounce_fsm_if.sv
// Signal bundle between the input conditioner and its user: enable and raw
// pin towards the conditioner, debounced level and edge strobes back.
interface sig_in_debounce_fsm_if;
  logic en;
  logic raw_in;
  logic sig_out;
  logic rise_pulse;
  logic fall_pulse;

  modport master (output en, raw_in, input sig_out, rise_pulse, fall_pulse);
  modport slave  (input en, raw_in, output sig_out, rise_pulse, fall_pulse);
endinterface

// File: rtl/sig_sync.sv
// Generic multi-flop synchroniser for an asynchronous single-bit input,
// cleared to 0 by the asynchronous reset.
module sig_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sig_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] chain_r;

  // Shift chain; runs every cycle regardless of any enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/sig_in_debounce_fsm.sv
// Input conditioner: synchronises raw_in and debounces it into sig_out.
// Define SIG_EDGE_PULSE_EN to get registered one-cycle rise/fall strobes.
module sig_in_debounce_fsm
  import sig_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  sig_in_debounce_fsm_if.slave  io
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("sig_in_debounce_fsm: DEBOUNCE_CYCLES must be >= 2");
  end

  logic             sync_s;
  sig_state_e       state_r;
  sig_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             sig_out_r;

  sig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io.raw_in),
    .q   (sync_s)
  );

  // Next-state and counter logic; en low holds everything.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (io.en) begin
      case (state_r)
        S_LOW: begin
          if (sync_s) begin
            state_nxt_s = S_WAIT_HIGH;
            cnt_nxt_s   = CNT_ONE;
          end else begin
            state_nxt_s = S_LOW;
          end
        end
        S_WAIT_HIGH: begin
          if (!sync_s) begin
            state_nxt_s = S_LOW;
            cnt_nxt_s   = '0;
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = S_HIGH;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync_s) begin
            state_nxt_s = S_WAIT_LOW;
            cnt_nxt_s   = CNT_ONE;
          end else begin
            state_nxt_s = S_HIGH;
          end
        end
        S_WAIT_LOW: begin
          if (sync_s) begin
            state_nxt_s = S_HIGH;
            cnt_nxt_s   = '0;
          end else if (cnt_r == CNT_LAST) begin
            state_nxt_s = S_LOW;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = S_LOW;
          cnt_nxt_s   = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // State, counter and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_LOW;
      cnt_r     <= '0;
      sig_out_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      sig_out_r <= level_of(state_nxt_s);
    end
  end

  assign io.sig_out = sig_out_r;

`ifdef SIG_EDGE_PULSE_EN
  logic rise_s;
  logic fall_s;
  logic rise_r;
  logic fall_r;

  // A strobe fires on the same edge the completing WAIT state commits the level.
  assign rise_s = io.en && (state_r == S_WAIT_HIGH) && sync_s  && (cnt_r == CNT_LAST);
  assign fall_s = io.en && (state_r == S_WAIT_LOW)  && !sync_s && (cnt_r == CNT_LAST);

  // Edge strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= rise_s;
      fall_r <= fall_s;
    end
  end

  assign io.rise_pulse = rise_r;
  assign io.fall_pulse = fall_r;
`else
  assign io.rise_pulse = 1'b0;
  assign io.fall_pulse = 1'b0;
`endif

endmodule
